// File: rtl/seq_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_pkg
// Description : Shared constants, width helper and control-state encoding for
//               the parametrised serial sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_detector_pkg;

    // Legacy-compatible defaults: 5-bit pattern 01101 with overlap enabled.
    localparam int               PKG_DEF_MAX_LEN = 8;
    localparam int               PKG_DEF_CNT_W   = 16;
    localparam logic [7:0]       PKG_DEF_PATTERN = 8'b0000_1101;
    localparam int               PKG_DEF_LEN     = 5;
    localparam bit               PKG_DEF_OVERLAP = 1'b1;

    // Width needed to hold any length 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Configuration/control state.
    typedef enum logic [0:0] {
        ACTIVE = 1'b0,
        FLUSH  = 1'b1
    } state_t;

endpackage : seq_detector_pkg
`default_nettype wire

// File: rtl/seq_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_if
// Description : Data, configuration and status bundle of the sequence
//               detector. The master drives stimulus/config, the slave is
//               the detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_detector_if
    import seq_detector_pkg::*;
#(
    parameter int MAX_LEN = PKG_DEF_MAX_LEN,
    parameter int CNT_W   = PKG_DEF_CNT_W,
    parameter int LEN_W   = len_width(MAX_LEN)
);

    logic               din;
    logic               valid;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               seq_det;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output din, valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  seq_det, match_cnt, cfg_err
    );

    modport slave (
        input  din, valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output seq_det, match_cnt, cfg_err
    );

endinterface : seq_detector_if
`default_nettype wire

// File: rtl/seq_detector_cfg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_cfg
// Description : Configuration registers of the sequence detector: legality
//               check, pattern masking, error pulse and one-cycle FLUSH
//               sequencing after reset release or a legal write.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_cfg
    import seq_detector_pkg::*;
#(
    parameter int                 MAX_LEN     = PKG_DEF_MAX_LEN,
    parameter int                 LEN_W       = len_width(MAX_LEN),
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
    parameter int                 DEF_LEN     = PKG_DEF_LEN,
    parameter bit                 DEF_OVERLAP = PKG_DEF_OVERLAP
)(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               cfg_we_i,
    input  wire logic [MAX_LEN-1:0] cfg_pattern_i,
    input  wire logic [LEN_W-1:0]   cfg_len_i,
    input  wire logic               cfg_overlap_i,
    output logic      [MAX_LEN-1:0] pattern_o,
    output logic      [LEN_W-1:0]   len_o,
    output logic                    overlap_o,
    output logic                    flush_o,
    output logic                    cfg_err_o
);

    // Keeps only the low 'len' bits so unused pattern bits are stored as zero.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    localparam logic [LEN_W-1:0]   C_DEF_LEN     = LEN_W'(DEF_LEN);
    localparam logic [MAX_LEN-1:0] C_DEF_PATTERN = DEF_PATTERN & len_mask(C_DEF_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               err_q, err_d;
    logic               w_len_ok;
    logic               w_load;

    // Legality check, next-state and next-config selection.
    always_comb begin
        w_len_ok  = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(MAX_LEN));
        w_load    = cfg_we_i && w_len_ok;
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        err_d     = cfg_we_i && !w_len_ok;

        case (state_q)
            ACTIVE:  state_d = w_load ? FLUSH : ACTIVE;
            FLUSH:   state_d = w_load ? FLUSH : ACTIVE;
            default: state_d = FLUSH;
        endcase

        if (w_load) begin
            pattern_d = cfg_pattern_i & len_mask(cfg_len_i);
            len_d     = cfg_len_i;
            overlap_d = cfg_overlap_i;
        end
    end

    // State and config registers; reset lands in FLUSH so the first cycle
    // after release drops any incoming bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FLUSH;
            pattern_q <= C_DEF_PATTERN;
            len_q     <= C_DEF_LEN;
            overlap_q <= DEF_OVERLAP;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            err_q     <= err_d;
        end
    end

    // A legal write clears history in its own cycle; FLUSH covers the next.
    assign flush_o   = w_load || (state_q == FLUSH);
    assign pattern_o = pattern_q;
    assign len_o     = len_q;
    assign overlap_o = overlap_q;
    assign cfg_err_o = err_q;

endmodule : seq_detector_cfg
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Runtime-programmable serial sequence detector with overlap /
//               non-overlap modes, valid-qualified input, registered
//               detection pulse and saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int                 MAX_LEN     = PKG_DEF_MAX_LEN,
    parameter int                 CNT_W       = PKG_DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
    parameter int                 DEF_LEN     = PKG_DEF_LEN,
    parameter bit                 DEF_OVERLAP = PKG_DEF_OVERLAP
)(
    input wire logic     clk,
    input wire logic     rst,
    seq_detector_if.slave bus
);

    localparam int LEN_W = len_width(MAX_LEN);

    logic [MAX_LEN-1:0] w_pattern;
    logic [LEN_W-1:0]   w_len;
    logic               w_overlap;
    logic               w_flush;
    logic               w_cfg_err;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q;

    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_hist_shift;
    logic [LEN_W-1:0]   w_fill_inc;
    logic               w_accept;
    logic               w_match;

    seq_detector_cfg #(
        .MAX_LEN     (MAX_LEN),
        .LEN_W       (LEN_W),
        .DEF_PATTERN (DEF_PATTERN),
        .DEF_LEN     (DEF_LEN),
        .DEF_OVERLAP (DEF_OVERLAP)
    ) u_cfg (
        .clk           (clk),
        .rst           (rst),
        .cfg_we_i      (bus.cfg_we),
        .cfg_pattern_i (bus.cfg_pattern),
        .cfg_len_i     (bus.cfg_len),
        .cfg_overlap_i (bus.cfg_overlap),
        .pattern_o     (w_pattern),
        .len_o         (w_len),
        .overlap_o     (w_overlap),
        .flush_o       (w_flush),
        .cfg_err_o     (w_cfg_err)
    );

    // Compare the post-shift history against the active pattern.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(w_len));
        end
        // A config write takes the cycle; its din is never sampled.
        w_accept     = bus.valid && !bus.cfg_we && !w_flush;
        w_hist_shift = {hist_q[MAX_LEN-2:0], bus.din};
        w_fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        w_match      = w_accept && (w_fill_inc >= w_len) &&
                       ((w_hist_shift & w_mask) == w_pattern);
    end

    // Next history/fill and saturating counter.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;

        if (w_flush) begin
            hist_d = '0;
            fill_d = '0;
        end else if (w_accept) begin
            hist_d = w_hist_shift;
            // Non-overlap restarts the fill so the next match needs len fresh bits.
            fill_d = (w_match && !w_overlap) ? '0 : w_fill_inc;
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (w_match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers and the one-cycle detection pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            det_q  <= w_match;
        end
    end

    assign bus.seq_det   = det_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = w_cfg_err;

endmodule : seq_detector_param
`default_nettype wire
